// File: rtl/refresh_pkg.sv
// Shared types and defaults for the DRAM refresh scheduler.
package refresh_pkg;

    localparam int unsigned MaxPendDefault = 4;
    localparam int unsigned UrgentDefault  = 3;
    localparam int unsigned PendW          = 3;

    typedef enum logic [1:0] {
        StIdle,
        StCpu,
        StRefresh
    } refState_e;

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for the PIT channel-1 output; reset preloads the history
// register with the live level so a high level at reset release is not a tick.
module tick_edge (
    input  logic iClk,
    input  logic iRst,
    input  logic iLevel,
    output logic oTick
);

    logic levelQ;

    // Same load in and out of reset: history always tracks the input.
    always_ff @(posedge iClk) begin
        levelQ <= iLevel;
    end

    assign oTick = iLevel & ~levelQ & ~iRst;

endmodule

// File: rtl/refresh_sched.sv
// Arbitrates the memory bus between the CPU and PIT-paced refresh cycles.
// Optional macro REFRESH_URGENT_EN lets a deep refresh backlog beat the CPU in IDLE.
module refresh_sched
    import refresh_pkg::*;
#(
    parameter int unsigned MAX_PEND = MaxPendDefault,
    parameter int unsigned URGENT   = UrgentDefault
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iOut1,
    input  logic             iCpuReq,
    input  logic             iCpuDone,
    input  logic             iRefDone,
    output logic             oCpuGnt,
    output logic             oRefReq,
    output logic [PendW-1:0] oPending,
    output logic             oOverrun
);

    if (MAX_PEND < 1 || MAX_PEND > 7) begin : gBadMaxPend
        $error("refresh_sched: MAX_PEND out of range");
    end
    if (URGENT < 1 || URGENT > MAX_PEND) begin : gBadUrgent
        $error("refresh_sched: URGENT out of range");
    end

    localparam logic [PendW-1:0] MaxPendV = PendW'(MAX_PEND);
`ifdef REFRESH_URGENT_EN
    localparam logic [PendW-1:0] UrgentV  = PendW'(URGENT);
`endif

    refState_e        stateQ, stateD;
    logic [PendW-1:0] pendQ, pendD;
    logic             overrunQ, overrunD;
    logic             tick;
    logic             refAccept;

    tick_edge uTickEdge (
        .iClk   (iClk),
        .iRst   (iRst),
        .iLevel (iOut1),
        .oTick  (tick)
    );

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
`ifdef REFRESH_URGENT_EN
                if (pendQ >= UrgentV) begin
                    stateD = StRefresh;
                end else if (iCpuReq) begin
                    stateD = StCpu;
                end else if (pendQ != '0) begin
                    stateD = StRefresh;
                end
`else
                if (iCpuReq) begin
                    stateD = StCpu;
                end else if (pendQ != '0) begin
                    stateD = StRefresh;
                end
`endif
            end
            StCpu:     if (iCpuDone) stateD = StIdle;
            StRefresh: if (iRefDone) stateD = StIdle;
            default:   stateD = StIdle;
        endcase
    end

    assign refAccept = (stateQ == StRefresh) && iRefDone;

    // A tick and a completed refresh in the same cycle cancel out.
    always_comb begin
        pendD    = pendQ;
        overrunD = overrunQ;
        if (tick && !refAccept) begin
            if (pendQ == MaxPendV) begin
                overrunD = 1'b1;
            end else begin
                pendD = pendQ + PendW'(1);
            end
        end else if (refAccept && !tick && pendQ != '0) begin
            pendD = pendQ - PendW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ   <= StIdle;
            pendQ    <= '0;
            overrunQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pendQ    <= pendD;
            overrunQ <= overrunD;
        end
    end

    assign oCpuGnt  = (stateQ == StCpu);
    assign oRefReq  = (stateQ == StRefresh);
    assign oPending = pendQ;
    assign oOverrun = overrunQ;

endmodule

// File: tb/tb_refresh_sched.sv
// Directed bench for refresh_sched with hand-computed expectations.
module tb_refresh_sched;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iOut1;
    logic       iCpuReq;
    logic       iCpuDone;
    logic       iRefDone;
    logic       oCpuGnt;
    logic       oRefReq;
    logic [2:0] oPending;
    logic       oOverrun;

    int checks   = 0;
    int failures = 0;
    int bothSeen = 0;

    refresh_sched #(
        .MAX_PEND (4),
        .URGENT   (3)
    ) uDut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iOut1    (iOut1),
        .iCpuReq  (iCpuReq),
        .iCpuDone (iCpuDone),
        .iRefDone (iRefDone),
        .oCpuGnt  (oCpuGnt),
        .oRefReq  (oRefReq),
        .oPending (oPending),
        .oOverrun (oOverrun)
    );

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge iClk);
        #1;
        if (oCpuGnt && oRefReq) bothSeen++;
    endtask

    initial begin
        int gntCycles;
        int refSeen;
        int refCount;
        int cpuSeen;

        iRst = 1'b1; iOut1 = 1'b1; iCpuReq = 1'b0; iCpuDone = 1'b0; iRefDone = 1'b0;
        repeat (3) step();
        checkVal("rst_gnt", int'(oCpuGnt), 0);
        checkVal("rst_ref", int'(oRefReq), 0);
        checkVal("rst_pend", int'(oPending), 0);
        checkVal("rst_ovr", int'(oOverrun), 0);

        // Level held high across reset release: no tick.
        iRst = 1'b0;
        repeat (3) step();
        checkVal("rel_pend", int'(oPending), 0);
        checkVal("rel_ref", int'(oRefReq), 0);
        iOut1 = 1'b0;
        step();

        for (int k = 0; k < 3; k++) begin
            iOut1 = 1'b1;
            step();
            checkVal($sformatf("tick%0d_pend", k), int'(oPending), 1);
            checkVal($sformatf("tick%0d_ref_lo", k), int'(oRefReq), 0);
            iOut1 = 1'b0;
            step();
            checkVal($sformatf("tick%0d_ref_hi", k), int'(oRefReq), 1);
            iRefDone = 1'b1;
            step();
            iRefDone = 1'b0;
            checkVal($sformatf("tick%0d_pend0", k), int'(oPending), 0);
            checkVal($sformatf("tick%0d_idle", k), int'(oRefReq), 0);
        end

        // Build pending=2 while in REFRESH, then coincide a tick with iRefDone.
        iOut1 = 1'b1; step();
        iOut1 = 1'b0; step();
        iOut1 = 1'b1; step();
        iOut1 = 1'b0; step();
        checkVal("coin_pre_pend", int'(oPending), 2);
        checkVal("coin_pre_ref", int'(oRefReq), 1);
        iOut1 = 1'b1; iRefDone = 1'b1;
        step();
        checkVal("coin_pend", int'(oPending), 2);
        checkVal("coin_idle", int'(oRefReq), 0);

        // Stray iRefDone while IDLE.
        iOut1 = 1'b0;
        step();
        iRefDone = 1'b0;
        checkVal("stray_ref_pend", int'(oPending), 2);
        checkVal("stray_ref_state", int'(oRefReq), 1);
        // Stray iCpuDone while in REFRESH.
        iCpuDone = 1'b1;
        step();
        iCpuDone = 1'b0;
        checkVal("stray_cpu_ref", int'(oRefReq), 1);
        checkVal("stray_cpu_gnt", int'(oCpuGnt), 0);
        checkVal("stray_cpu_pend", int'(oPending), 2);
        iRefDone = 1'b1; step();
        iRefDone = 1'b0; step();
        iRefDone = 1'b1; step();
        iRefDone = 1'b0;
        checkVal("drain_pend", int'(oPending), 0);
        step();
        checkVal("drain_idle", int'(oRefReq), 0);

        // CPU hogs the bus with 4-cycle transactions while 6 ticks arrive.
        iCpuReq = 1'b1;
        gntCycles = 0;
        refSeen = 0;
        for (int c = 0; c < 32; c++) begin
            iOut1 = (c < 24) && (c % 4 >= 2);
            step();
            if (oRefReq) refSeen++;
            if (oCpuGnt) begin
                if (gntCycles == 3) begin
                    iCpuDone = 1'b1;
                    gntCycles = 0;
                end else begin
                    iCpuDone = 1'b0;
                    gntCycles++;
                end
            end else begin
                iCpuDone = 1'b0;
            end
        end
        checkVal("sat_pend", int'(oPending), 4);
        checkVal("sat_ovr", int'(oOverrun), 1);
        checkVal("sat_no_ref", refSeen, 0);

        // Drop the CPU request and let the backlog drain.
        iCpuReq = 1'b0;
        refCount = 0;
        for (int c = 0; c < 40; c++) begin
            if (oRefReq && iRefDone) refCount++;
            step();
            if (oCpuGnt) begin
                if (gntCycles == 3) begin
                    iCpuDone = 1'b1;
                    gntCycles = 0;
                end else begin
                    iCpuDone = 1'b0;
                    gntCycles++;
                end
            end else begin
                iCpuDone = 1'b0;
            end
            iRefDone = oRefReq && !iRefDone;
        end
        iRefDone = 1'b0;
        checkVal("drain4_count", refCount, 4);
        checkVal("drain4_pend", int'(oPending), 0);
        checkVal("drain4_ovr_sticky", int'(oOverrun), 1);
        checkVal("drain4_idle", int'(oRefReq), 0);

        // Three ticks during a CPU transaction, then see who wins IDLE.
        iCpuReq = 1'b1;
        step();
        checkVal("urg_gnt", int'(oCpuGnt), 1);
        for (int k = 0; k < 3; k++) begin
            iOut1 = 1'b1; step();
            iOut1 = 1'b0; step();
        end
        checkVal("urg_pend", int'(oPending), 3);
        checkVal("urg_hold_gnt", int'(oCpuGnt), 1);
        iCpuDone = 1'b1;
        step();
        iCpuDone = 1'b0;
        checkVal("urg_idle_gnt", int'(oCpuGnt), 0);
        checkVal("urg_idle_ref", int'(oRefReq), 0);
        step();
        cpuSeen = int'(oCpuGnt);
`ifdef REFRESH_URGENT_EN
        checkVal("urg_ref_wins", int'(oRefReq), 1);
        checkVal("urg_cpu_loses", cpuSeen, 0);
`else
        checkVal("cpu_wins_ref", int'(oRefReq), 0);
        checkVal("cpu_wins_gnt", cpuSeen, 1);
`endif

        // Reset in the middle of a CPU grant.
        iRst = 1'b1; step(); iRst = 1'b0;
        iCpuReq = 1'b1;
        step();
        checkVal("mid_gnt", int'(oCpuGnt), 1);
        iOut1 = 1'b1; step();
        iOut1 = 1'b0;
        checkVal("mid_pend", int'(oPending), 1);
        iRst = 1'b1;
        step();
        checkVal("mid_rst_gnt", int'(oCpuGnt), 0);
        checkVal("mid_rst_pend", int'(oPending), 0);
        checkVal("mid_rst_ovr", int'(oOverrun), 0);
        checkVal("mid_rst_ref", int'(oRefReq), 0);
        step();
        checkVal("mid_rst_hold", int'(oCpuGnt), 0);
        iRst = 1'b0; iCpuReq = 1'b0;
        step();
        checkVal("post_rst_pend", int'(oPending), 0);

        checkVal("never_both", bothSeen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/refresh_sched.md
REFRESH_SCHED -- requirements
Module: refresh_sched

Interface
REQ-001: Parameter MAX_PEND, default 4, saturation limit of the pending-refresh counter (1..7).
REQ-002: Parameter URGENT, default 3, pending count at which refresh preempts CPU (1..MAX_PEND; used only with the macro in REQ-021).
REQ-003: iClk  input  1  system clock; the block has one clock.
REQ-004: iRst  input  1  reset, synchronous, active-high.
REQ-005: iOut1  input  1  PIT channel-1 output level, synchronous to iClk.
REQ-006: iCpuReq  input  1  CPU memory-bus request level.
REQ-007: iCpuDone  input  1  one-cycle pulse ending the granted CPU transaction.
REQ-008: iRefDone  input  1  one-cycle pulse ending the issued refresh cycle.
REQ-009: oCpuGnt  output  1  CPU owns the memory bus.
REQ-010: oRefReq  output  1  refresh cycle in progress or requested.
REQ-011: oPending  output  3  current pending-refresh count.
REQ-012: oOverrun  output  1  sticky flag for a tick lost at saturation.

Function
REQ-013: A tick SHALL be a rising edge of iOut1, detected against a registered copy of iOut1; level or falling edge produces no tick.
REQ-014: Each tick SHALL increment the pending count, saturating at MAX_PEND; a tick at MAX_PEND SHALL set oOverrun on the next cycle and leave the count unchanged.
REQ-015: iRefDone accepted in REFRESH SHALL decrement the pending count by 1; a simultaneous tick and iRefDone SHALL leave the count unchanged.
REQ-016: FSM states SHALL be IDLE, CPU and REFRESH, one-hot or binary at implementer choice.
REQ-017: IDLE priority, highest first: urgent refresh (REQ-021 only) -> REFRESH; iCpuReq=1 -> CPU; pending!=0 -> REFRESH; otherwise stay in IDLE.
REQ-018: CPU SHALL hold until iCpuDone=1, then go to IDLE; REFRESH SHALL hold until iRefDone=1, then go to IDLE.
REQ-019: oCpuGnt and oRefReq SHALL be registered and equal (state==CPU) and (state==REFRESH); they SHALL never both be high. The grant rises one cycle after the request is sampled in IDLE. At least one IDLE cycle SHALL separate consecutive grants.
REQ-020: iCpuDone outside CPU and iRefDone outside REFRESH SHALL be ignored; they SHALL cause no count change and no state change.

Configuration
REQ-021: With macro REFRESH_URGENT_EN defined, pending>=URGENT in IDLE SHALL select REFRESH even if iCpuReq=1. Without it, the URGENT parameter SHALL be unused and the CPU always wins in IDLE.
REQ-022: Neither build SHALL preempt a transaction already granted.

Reset
REQ-023: While iRst=1, the block SHALL hold: state=IDLE, oCpuGnt=0, oRefReq=0, oPending=0, oOverrun=0.
REQ-024: While iRst=1, the iOut1 history register SHALL load the current iOut1, so no tick fires on the first cycle after reset.
REQ-025: Reset asserted mid-transaction SHALL drop the grant on the next edge; the pending count is lost.

Structure
REQ-026: Package refresh_pkg SHALL hold the state enumeration, the MAX_PEND and URGENT defaults, and the pending-count width constant (3).
REQ-027: Sub-module tick_edge (one register, rising-edge pulse, reset load per REQ-024) SHALL do the tick detection; the FSM, counter and flag SHALL live in refresh_sched.

Verification
REQ-028: Reset, iOut1=1 held through reset release -> no tick; oPending stays 0; oRefReq=0.
REQ-029: Three iOut1 rising edges with iCpuReq=0 -> oPending reaches 1 each time; oRefReq rises one cycle after the first tick; iRefDone after each refresh -> oPending returns to 0 and the FSM returns to IDLE.
REQ-030: Keep iCpuReq=1 with back-to-back 4-cycle transactions; give 6 ticks, no macro, MAX_PEND=4 -> oPending=4, oOverrun=1, oRefReq never rises; drop iCpuReq -> 4 refreshes in sequence.
REQ-031: REFRESH_URGENT_EN, URGENT=3, iCpuReq=1, 3 ticks during a CPU transaction -> after iCpuDone and one IDLE cycle, oRefReq=1 rather than oCpuGnt.
REQ-032: Tick coincident with iRefDone at oPending=2 -> oPending stays 2.
REQ-033: Stray iRefDone pulse in IDLE, and stray iCpuDone pulse in REFRESH -> no change to state or oPending.
REQ-034: Assert iRst during CPU grant -> oCpuGnt=0 the next cycle; oPending=0; oOverrun=0.
